apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 53 +++++
 rtl/apb_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_if
//  Description : Bundle of the command/response handshake and the APB bus
//                signals that surround apb_master.
//                master modport - the apb_master view of the bundle.
//                slave  modport - the command requester plus APB slave view.
//  Signals     : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  command
//                rsp_valid/rsp_ready/rsp_rdata/rsp_err             response
//                PSEL/PENABLE/PWRITE/PADDR/PWDATA                  APB request
//                PRDATA/PREADY/PSLVERR                             APB reply
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // command channel
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   // response channel
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   // APB bus
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master
//  Description : Single-outstanding APB master. Accepts one command, runs an
//                IDLE -> SETUP -> ACCESS transfer and returns a response that
//                is held until consumed.
//  Ports       : PClk     - clock, rising edge
//                PRESETn  - synchronous active-low reset
//                apb      - apb_master_if.master (command, response, APB bus)
//  Parameters  : ADDR_WIDTH, DATA_WIDTH, TIMEOUT_CYCLES
//  Options     : APB_MST_TIMEOUT_EN - when defined, an ACCESS phase that sees
//                PREADY low for TIMEOUT_CYCLES cycles ends with rsp_err=1 and
//                rsp_rdata=0. When undefined, ACCESS waits for PREADY forever.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  wire logic     PClk,
   input  wire logic     PRESETn,
   apb_master_if.master  apb
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   logic                  r_idle_en;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   state_t                w_state_nxt;
   logic                  w_psel_nxt;
   logic                  w_penable_nxt;
   logic                  w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0] w_paddr_nxt;
   logic [DATA_WIDTH-1:0] w_pwdata_nxt;
   logic                  w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
   logic                  w_rsp_err_nxt;

   logic                  w_cmd_ready;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_tmo;

   // r_idle_en is a registered "in IDLE and out of reset" flag. It is
   // qualified by rsp_ready in the same cycle so a response handshake and a
   // new command can coincide, giving one IDLE cycle between transfers.
   assign w_cmd_ready = r_idle_en && (!r_rsp_valid || apb.rsp_ready);
   assign w_accept    = w_cmd_ready && apb.cmd_valid;
   // PREADY is only looked at while in ACCESS.
   assign w_done      = (r_state == ST_ACCESS) && (apb.PREADY || w_tmo);

`ifdef APB_MST_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [c_CNT_W-1:0] r_tmo_cnt;

   // Fires on the ACCESS cycle whose stalled edge would make the count
   // reach TIMEOUT_CYCLES.
   assign w_tmo = (r_state == ST_ACCESS) && !apb.PREADY &&
                  (r_tmo_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PClk) begin
      if (!PRESETn) begin
         r_tmo_cnt <= '0;
      end else if (w_accept) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !apb.PREADY && !w_tmo) begin
         r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_psel_nxt      = r_psel;
      w_penable_nxt   = r_penable;
      w_pwrite_nxt    = r_pwrite;
      w_paddr_nxt     = r_paddr;
      w_pwdata_nxt    = r_pwdata;
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt   = ST_SETUP;
               w_psel_nxt    = 1'b1;
               w_penable_nxt = 1'b0;
               w_pwrite_nxt  = apb.cmd_write;
               w_paddr_nxt   = {apb.cmd_addr[ADDR_WIDTH-1:2], 2'b00};
               w_pwdata_nxt  = apb.cmd_wdata;
            end
         end
         ST_SETUP: begin
            w_state_nxt   = ST_ACCESS;
            w_penable_nxt = 1'b1;
         end
         ST_ACCESS: begin
            if (w_done) begin
               w_state_nxt   = ST_IDLE;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
         end
      endcase

      // Consumed responses clear; a completing transfer loads over that.
      if (r_rsp_valid && apb.rsp_ready) begin
         w_rsp_valid_nxt = 1'b0;
         w_rsp_rdata_nxt = '0;
         w_rsp_err_nxt   = 1'b0;
      end
      if (w_done) begin
         w_rsp_valid_nxt = 1'b1;
         w_rsp_err_nxt   = w_tmo ? 1'b1 : apb.PSLVERR;
         w_rsp_rdata_nxt = (w_tmo || r_pwrite) ? '0 : apb.PRDATA;
      end
   end

   // State and output registers
   always_ff @(posedge PClk) begin
      if (!PRESETn) begin
         r_state     <= ST_IDLE;
         r_idle_en   <= 1'b0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idle_en   <= (w_state_nxt == ST_IDLE);
         r_psel      <= w_psel_nxt;
         r_penable   <= w_penable_nxt;
         r_pwrite    <= w_pwrite_nxt;
         r_paddr     <= w_paddr_nxt;
         r_pwdata    <= w_pwdata_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign apb.cmd_ready = w_cmd_ready;
   assign apb.rsp_valid = r_rsp_valid;
   assign apb.rsp_rdata = r_rsp_rdata;
   assign apb.rsp_err   = r_rsp_err;
   assign apb.PSEL      = r_psel;
   assign apb.PENABLE   = r_penable;
   assign apb.PWRITE    = r_pwrite;
   assign apb.PADDR     = r_paddr;
   assign apb.PWDATA    = r_pwdata;

endmodule
`default_nettype wire
